// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
// The state encoding is visible on the debug output, so it is fixed here.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b11,
    RELEASE_WAIT = 2'b10
  } chan_state_e;

  // The counter must be able to hold HOLD_CYC itself, because it saturates there.
  function automatic int cnt_width(input int hold_cyc);
    return $clog2(hold_cyc + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button channel: input synchroniser, press/hold/release FSM, and
// shared stability/hold counter. All outputs are registered.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int HOLD_CYC    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        b_i,
  output logic        level_o,
  output logic        press_o,
  output logic        rel_o,
  output logic        hold_o,
  output chan_state_e state_o
);

  localparam int CW = cnt_width(HOLD_CYC);
  localparam logic [CW-1:0] CNT_STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_HOLD_FIRE   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX         = CW'(HOLD_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   bs;

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_done_q, hold_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hold_q, hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], b_i};
    end
  end

  assign bs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_done_q <= hold_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_done_d = hold_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    hold_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bs) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!bs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_STABLE_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (bs) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_HOLD_FIRE && !hold_done_q) begin
            hold_d      = 1'b1;
            hold_done_d = 1'b1;
          end
        end else begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 resumes the press silently; hold_done survives it.
        if (bs) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_STABLE_LAST) begin
          state_d     = IDLE;
          level_d     = 1'b0;
          rel_d       = 1'b1;
          hold_done_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign hold_o  = hold_q;
  assign state_o = state_q;

endmodule

// File: rtl/debounce_multi_fsm.sv
// N_CH independent debounced buttons; state_dbg packs each channel's FSM state
// (2 bits per channel, channel 0 in the low bits).
module debounce_multi_fsm
  import debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int STABLE_CYC  = 4,
  parameter int HOLD_CYC    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   b,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   press,
  output logic [N_CH-1:0]   rel,
  output logic [N_CH-1:0]   hold,
  output logic [2*N_CH-1:0] state_dbg
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    chan_state_e st;

    debounce_chan #(
      .STABLE_CYC (STABLE_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .b_i    (b[i]),
      .level_o(level[i]),
      .press_o(press[i]),
      .rel_o  (rel[i]),
      .hold_o (hold[i]),
      .state_o(st)
    );

    assign state_dbg[2*i +: 2] = st;
  end

endmodule

// File: doc/debounce_multi_fsm.md
DEBOUNCE_MULTI_FSM -- requirements
Module: debounce_multi_fsm

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter STABLE_CYC, default 4: consecutive identical synchronised samples needed to accept a transition (2..255).
REQ-003 SHALL have parameter HOLD_CYC, default 16: cycles in HELD before a long-press pulse (STABLE_CYC+1..65535).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (2..4).
REQ-005 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port b  input  N_CH  raw asynchronous button inputs.
REQ-008 SHALL have port level  output  N_CH  debounced button state, 1 = pressed.
REQ-009 SHALL have port press  output  N_CH  one-cycle pulse on each accepted press.
REQ-010 SHALL have port rel  output  N_CH  one-cycle pulse on each accepted release.
REQ-011 SHALL have port hold  output  N_CH  one-cycle long-press pulse, at most once per press.

Function
REQ-012 SHALL pass each b[i] through SYNC_STAGES flops; the last stage output is bs[i], and only bs[i] drives channel i.
REQ-013 SHALL run one FSM per channel with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT; channels SHALL NOT interact.
REQ-014 SHALL, in IDLE: go to PRESS_WAIT with cnt=1 if bs=1; otherwise stay.
REQ-015 SHALL, in PRESS_WAIT: go to IDLE with cnt=0 if bs=0; go to HELD with level=1, press=1 for one cycle and cnt=0 if bs=1 and cnt==STABLE_CYC-1; otherwise increment cnt.
REQ-016 SHALL, in HELD with bs=1: increment cnt, saturating at HOLD_CYC; assert hold for one cycle when cnt reaches HOLD_CYC-1 and hold_done=0, then set hold_done=1.
REQ-017 SHALL, in HELD with bs=0: go to RELEASE_WAIT with cnt=1; level stays 1.
REQ-018 SHALL, in RELEASE_WAIT: go back to HELD with cnt=0 if bs=1, with no press pulse and hold_done kept; go to IDLE with level=0, rel=1 for one cycle and hold_done=0 if bs=0 and cnt==STABLE_CYC-1; otherwise increment cnt.
REQ-019 SHALL register all outputs. Latency is SYNC_STAGES+STABLE_CYC cycles from a clean b edge to the press or rel pulse.
REQ-020 SHALL size cnt as $clog2(HOLD_CYC+1) bits and SHALL never let it wrap.
REQ-021 SHALL never assert press and rel together on the same channel; hold SHALL only assert while level=1.
REQ-022 SHALL treat pulses shorter than STABLE_CYC synchronised cycles as glitches, producing no output change.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force every channel to IDLE, with cnt=0, hold_done=0, level=0, press=0, rel=0, hold=0 and all synchroniser flops at 0.
REQ-024 SHALL, on reset assertion mid-operation (including HELD), drop level to 0 immediately without a rel pulse.
REQ-025 SHALL treat a button held through reset deassertion as a fresh press, requiring STABLE_CYC samples after synchronisation.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'b00, PRESS_WAIT=2'b01, HELD=2'b11, RELEASE_WAIT=2'b10) in shared package debounce_pkg.
REQ-027 SHALL implement one channel (synchroniser, FSM, counter) as sub-module debounce_chan, instantiated N_CH times by generate.

Verification (N_CH=4, STABLE_CYC=4, HOLD_CYC=16, SYNC_STAGES=2)
REQ-028 SHALL check a clean press: b[0] 0->1 held 30 cycles -> press[0] pulses 6 cycles after the edge, level[0]=1, hold[0] pulses once 16 cycles after press, no second hold.
REQ-029 SHALL check glitch rejection: b[1]=1 for 3 cycles then 0 -> press, level, rel and hold all stay 0.
REQ-030 SHALL check release bounce: in HELD, b[2] toggles 0/1/0/1 with 2-cycle phases, then 0 for 10 cycles -> exactly one rel[2], 6 cycles after the final falling edge, and no extra press.
REQ-031 SHALL check channel independence: b[3:0] pressed on staggered cycles 0,1,2,3 -> press bits pulse on cycles 6,7,8,9 respectively.
REQ-032 SHALL check reset mid-hold: rst_n=0 while level[0]=1 -> level[0]=0 asynchronously, no rel; with b[0] still 1 after release, press[0] recurs 6 cycles later.
